// File: rtl/bp_update_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl_pkg
//   Shared definitions for the branch-predictor update controller: BTB field
//   widths, the invalid-entry marker, FSM state encodings, the packed BTB
//   update record carried through the update FIFO, and the saturating
//   2-bit counter step.
// -----------------------------------------------------------------------------
package bp_update_ctrl_pkg;

   localparam int WORD_SIZE      = 16;
   localparam int BTB_INDEX_BITS = 8;
   localparam int BTB_TAG_BITS   = 8;

   localparam logic [WORD_SIZE-1:0] BTB_INVALID = 16'hFFFF;

   typedef enum logic {
      ST_INIT = 1'b0,   // clearing every BTB entry
      ST_RUN  = 1'b1    // accepting resolved branches, draining updates
   } bp_state_e;

   // Field order fixes the 32-bit FIFO word layout: {index, tag, target}.
   typedef struct packed {
      logic [BTB_INDEX_BITS-1:0] index;
      logic [BTB_TAG_BITS-1:0]   tag;
      logic [WORD_SIZE-1:0]      target;
   } btb_entry_t;

   // One step of the global 2-bit counter: toward 11 when taken, toward 00
   // when not taken, holding at either end.
   function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic up);
      logic [1:0] nxt;
      nxt = cur;
      if (up && cur != 2'b11)
         nxt = cur + 2'd1;
      else if (!up && cur != 2'b00)
         nxt = cur - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// -----------------------------------------------------------------------------
// bp_update_fifo
//   Synchronous FIFO holding pending BTB updates between the resolve side and
//   the BTB write port. The head word is read straight from storage, so it is
//   stable for as long as the entry sits at the front.
// Ports
//   clk        in   clock
//   reset_n    in   synchronous active-low reset (empties the FIFO)
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit word to enqueue
//   pop        in   drop the head word (ignored when empty)
//   full       out  DEPTH words held
//   empty      out  no words held
//   head       out  oldest word held (meaningful when ~empty)
// -----------------------------------------------------------------------------
module bp_update_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;
   assign head      = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: sequential state is assigned with <= so every register samples the
   // values from before the edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; emptiness is tracked by the
   // pointers alone, and leaving the array unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl
//   Branch-predictor update sequencer. After reset it clears every BTB entry
//   (target 16'hFFFF), then accepts resolved branches: it raises a one-cycle
//   flush with the correct next PC on a misprediction, steps the global 2-bit
//   saturating counter, and queues one BTB write per resolved branch, draining
//   the queue in order to the BTB write port.
// Optional feature
//   BP_STATS_EN  when defined, adds saturating stat_branches / stat_mispred
//                counters and their output ports.
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   res_valid/ready     resolved-branch handshake (transfer = valid & ready)
//   res_pc, res_target  branch PC and its always-taken target
//   res_taken           actual outcome
//   res_pred_pc         next PC the predictor supplied
//   flush, redirect_pc  one-cycle flush and the correct next PC
//   pred_state          global counter, 00 strong NT .. 11 strong T
//   btb_wr_*            BTB write port (en/ready handshake, index/tag/target)
//   init_done           BTB clear finished
//   stat_branches       (BP_STATS_EN) resolved branches accepted
//   stat_mispred        (BP_STATS_EN) mispredictions seen
// -----------------------------------------------------------------------------
module bp_update_ctrl
   import bp_update_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int BTB_ENTRIES = 256
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      res_valid,
   output logic                      res_ready,
   input  logic [WORD_SIZE-1:0]      res_pc,
   input  logic [WORD_SIZE-1:0]      res_target,
   input  logic                      res_taken,
   input  logic [WORD_SIZE-1:0]      res_pred_pc,
   output logic                      flush,
   output logic [WORD_SIZE-1:0]      redirect_pc,
   output logic [1:0]                pred_state,
   output logic                      btb_wr_en,
   input  logic                      btb_wr_ready,
   output logic [BTB_INDEX_BITS-1:0] btb_wr_index,
   output logic [BTB_TAG_BITS-1:0]   btb_wr_tag,
   output logic [WORD_SIZE-1:0]      btb_wr_target,
   output logic                      init_done
`ifdef BP_STATS_EN
   ,
   output logic [15:0]               stat_branches,
   output logic [15:0]               stat_mispred
`endif
);

   localparam logic [BTB_INDEX_BITS-1:0] LAST_INDEX = BTB_INDEX_BITS'(BTB_ENTRIES - 1);

   bp_state_e                 r_state;
   bp_state_e                 w_state_next;
   logic [BTB_INDEX_BITS-1:0] r_init_idx;
   logic                      r_init_done;
   logic                      r_flush;
   logic [WORD_SIZE-1:0]      r_redirect_pc;
   logic [1:0]                r_pred_state;

   logic                      w_xfer;
   logic [WORD_SIZE-1:0]      w_correct_pc;
   logic                      w_mispred;
   logic                      w_pop;
   logic                      w_full;
   logic                      w_empty;
   btb_entry_t                w_push_entry;
   btb_entry_t                w_head;

   assign w_xfer       = res_valid & res_ready;
   assign w_correct_pc = res_taken ? res_target : res_pc + 16'd1;
   assign w_mispred    = (res_pred_pc != w_correct_pc);
   assign w_push_entry = '{index:  res_pc[BTB_INDEX_BITS-1:0],
                           tag:    res_pc[WORD_SIZE-1:BTB_INDEX_BITS],
                           target: res_target};

   bp_update_fifo #(
      .WIDTH ($bits(btb_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_xfer),
      .push_data (w_push_entry),
      .pop       (w_pop),
      .full      (w_full),
      .empty     (w_empty),
      .head      (w_head)
   );

   // ---------------------------------------------------------------- FSM --
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_INIT;
      else          r_state <= w_state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      w_state_next  = r_state;
      res_ready     = 1'b0;
      btb_wr_en     = 1'b0;
      btb_wr_index  = w_head.index;
      btb_wr_tag    = w_head.tag;
      btb_wr_target = w_head.target;
      w_pop         = 1'b0;
      case (r_state)
         ST_INIT: begin
            btb_wr_en     = 1'b1;
            btb_wr_index  = r_init_idx;
            btb_wr_tag    = '0;
            btb_wr_target = BTB_INVALID;
            if (btb_wr_ready && r_init_idx == LAST_INDEX)
               w_state_next = ST_RUN;
         end
         ST_RUN: begin
            // No bypass: a full queue refuses even when it pops this cycle.
            res_ready = ~w_full;
            btb_wr_en = ~w_empty;
            w_pop     = ~w_empty & btb_wr_ready;
         end
         default: w_state_next = ST_INIT;
      endcase
   end

   // ------------------------------------------------------ datapath regs --
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_init_idx    <= '0;
         r_init_done   <= 1'b0;
         r_flush       <= 1'b0;
         r_redirect_pc <= '0;
         r_pred_state  <= 2'b11;
      end else begin
         if (r_state == ST_INIT && btb_wr_ready) begin
            r_init_idx <= r_init_idx + 1'b1;
            if (r_init_idx == LAST_INDEX)
               r_init_done <= 1'b1;
         end
         // Flush is a pulse tied to a single transfer; queued updates are
         // untouched because they belong to older, already resolved branches.
         r_flush <= w_xfer & w_mispred;
         if (w_xfer && w_mispred)
            r_redirect_pc <= w_correct_pc;
         if (w_xfer)
            r_pred_state <= sat_step(r_pred_state, res_taken);
      end
   end

   assign flush       = r_flush;
   assign redirect_pc = r_redirect_pc;
   assign pred_state  = r_pred_state;
   assign init_done   = r_init_done;

`ifdef BP_STATS_EN
   logic [15:0] r_stat_branches;
   logic [15:0] r_stat_mispred;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_stat_branches <= '0;
         r_stat_mispred  <= '0;
      end else begin
         if (w_xfer && r_stat_branches != 16'hFFFF)
            r_stat_branches <= r_stat_branches + 16'd1;
         if (w_xfer && w_mispred && r_stat_mispred != 16'hFFFF)
            r_stat_mispred <= r_stat_mispred + 16'd1;
      end
   end

   assign stat_branches = r_stat_branches;
   assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bp_update_ctrl
//   Directed bench for bp_update_ctrl. A queue-based reference model advances
//   on every falling edge and is compared against the DUT outputs; directed
//   sequences add hand-computed literal expectations.
//   Inputs change 1 time unit after the rising edge; outputs are read there or
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_bp_update_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_pc;
   logic [15:0] res_target;
   logic        res_taken;
   logic [15:0] res_pred_pc;
   logic        flush;
   logic [15:0] redirect_pc;
   logic [1:0]  pred_state;
   logic        btb_wr_en;
   logic        btb_wr_ready;
   logic [7:0]  btb_wr_index;
   logic [7:0]  btb_wr_tag;
   logic [15:0] btb_wr_target;
   logic        init_done;
`ifdef BP_STATS_EN
   logic [15:0] stat_branches;
   logic [15:0] stat_mispred;
`endif

   bp_update_ctrl #(.FIFO_DEPTH(DEPTH), .BTB_ENTRIES(256)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_pc        (res_pc),
      .res_target    (res_target),
      .res_taken     (res_taken),
      .res_pred_pc   (res_pred_pc),
      .flush         (flush),
      .redirect_pc   (redirect_pc),
      .pred_state    (pred_state),
      .btb_wr_en     (btb_wr_en),
      .btb_wr_ready  (btb_wr_ready),
      .btb_wr_index  (btb_wr_index),
      .btb_wr_tag    (btb_wr_tag),
      .btb_wr_target (btb_wr_target),
      .init_done     (init_done)
`ifdef BP_STATS_EN
      ,
      .stat_branches (stat_branches),
      .stat_mispred  (stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // --------------------------------------------------- reference model --
   // State mirrors what the DUT shows after the latest rising edge.
   bit          m_valid = 1'b0;
   bit          m_init;
   int          m_cnt;
   logic [31:0] m_q[$];
   bit          m_flush;
   logic [15:0] m_redir;
   int          m_pred;
   bit          m_done;
   int          m_br;
   int          m_mp;
   bit          m_xfer;
   logic [15:0] m_corr;

   always @(negedge clk) begin
      if (m_valid) begin
         check("m_res_ready", {31'b0, res_ready}, {31'b0, !m_init && m_q.size() < DEPTH});
         check("m_btb_wr_en", {31'b0, btb_wr_en}, {31'b0, m_init || m_q.size() > 0});
         if (m_init) begin
            check("m_init_index",  {24'b0, btb_wr_index}, m_cnt);
            check("m_init_tag",    {24'b0, btb_wr_tag}, 32'h0);
            check("m_init_target", {16'b0, btb_wr_target}, 32'hFFFF);
         end else if (m_q.size() > 0) begin
            check("m_head_index",  {24'b0, btb_wr_index}, {24'b0, m_q[0][31:24]});
            check("m_head_tag",    {24'b0, btb_wr_tag}, {24'b0, m_q[0][23:16]});
            check("m_head_target", {16'b0, btb_wr_target}, {16'b0, m_q[0][15:0]});
         end
         check("m_flush", {31'b0, flush}, {31'b0, m_flush});
         if (m_flush)
            check("m_redirect_pc", {16'b0, redirect_pc}, {16'b0, m_redir});
         check("m_pred_state", {30'b0, pred_state}, m_pred);
         check("m_init_done", {31'b0, init_done}, {31'b0, m_done});
`ifdef BP_STATS_EN
         check("m_stat_branches", {16'b0, stat_branches}, m_br);
         check("m_stat_mispred",  {16'b0, stat_mispred}, m_mp);
`endif
      end

      if (!reset_n) begin
         m_valid = 1'b1;
         m_init  = 1'b1;
         m_cnt   = 0;
         m_q.delete();
         m_flush = 1'b0;
         m_redir = 16'h0;
         m_pred  = 3;
         m_done  = 1'b0;
         m_br    = 0;
         m_mp    = 0;
      end else if (m_valid) begin
         if (m_init) begin
            m_flush = 1'b0;
            if (btb_wr_ready) begin
               if (m_cnt == 255) begin
                  m_init = 1'b0;
                  m_done = 1'b1;
               end else begin
                  m_cnt++;
               end
            end
         end else begin
            m_xfer = res_valid && (m_q.size() < DEPTH);
            m_corr = res_taken ? res_target : res_pc + 16'd1;
            if (m_q.size() > 0 && btb_wr_ready)
               void'(m_q.pop_front());
            m_flush = m_xfer && (res_pred_pc != m_corr);
            if (m_flush) m_redir = m_corr;
            if (m_xfer) begin
               m_q.push_back({res_pc[7:0], res_pc[15:8], res_target});
               if (res_taken) m_pred = (m_pred < 3) ? m_pred + 1 : 3;
               else           m_pred = (m_pred > 0) ? m_pred - 1 : 0;
               if (m_br < 65535) m_br++;
               if (m_flush && m_mp < 65535) m_mp++;
            end
         end
      end
   end

   // -------------------------------------------------- directed stimulus --
   task automatic present(input logic [15:0] pc, input logic [15:0] tgt,
                          input logic taken, input logic [15:0] pred);
      res_valid   = 1'b1;
      res_pc      = pc;
      res_target  = tgt;
      res_taken   = taken;
      res_pred_pc = pred;
   endtask

   task automatic wait_init(input string name);
      int cyc;
      cyc = 0;
      while (!init_done && cyc < 2000) begin
         tick();
         cyc++;
      end
      check(name, cyc, 256);
   endtask

   int exp_idx;
   int exp_pred[4] = '{2, 1, 0, 0};

   initial begin
      reset_n      = 1'b0;
      res_valid    = 1'b0;
      res_pc       = '0;
      res_target   = '0;
      res_taken    = 1'b0;
      res_pred_pc  = '0;
      btb_wr_ready = 1'b1;
      repeat (3) tick();

      // 1: reset state, full clear with ready held high.
      check("t1_rst_pred_state", {30'b0, pred_state}, 32'd3);
      check("t1_rst_init_done",  {31'b0, init_done}, 32'd0);
      check("t1_rst_flush",      {31'b0, flush}, 32'd0);
      check("t1_rst_res_ready",  {31'b0, res_ready}, 32'd0);
      reset_n = 1'b1;
      check("t1_first_index", {24'b0, btb_wr_index}, 32'd0);
      check("t1_first_en",    {31'b0, btb_wr_en}, 32'd1);
      wait_init("t1_init_cycles");
      check("t1_res_ready", {31'b0, res_ready}, 32'd1);
      check("t1_pred_state", {30'b0, pred_state}, 32'd3);
      check("t1_idle_wr_en", {31'b0, btb_wr_en}, 32'd0);

      // 2: ready toggling during INIT, then reset at index 100.
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      exp_idx = 0;
      for (int c = 0; c < 200; c++) begin
         btb_wr_ready = (c % 2 == 0);
         tick();
         if (c % 2 == 0) exp_idx++;
         check("t2_index_step", {24'b0, btb_wr_index}, exp_idx);
      end
      check("t2_index_100", {24'b0, btb_wr_index}, 32'd100);
      check("t2_not_done", {31'b0, init_done}, 32'd0);
      reset_n = 1'b0;
      tick();
      check("t2_restart_index", {24'b0, btb_wr_index}, 32'd0);
      reset_n      = 1'b1;
      btb_wr_ready = 1'b1;
      wait_init("t2_init_cycles");

      // 3: not-taken branch predicted taken -> flush to PC+1.
      present(16'h1234, 16'h1240, 1'b0, 16'h1240);
      tick();
      res_valid = 1'b0;
      check("t3_flush",      {31'b0, flush}, 32'd1);
      check("t3_redirect",   {16'b0, redirect_pc}, 32'h1235);
      check("t3_pred_state", {30'b0, pred_state}, 32'd2);
      check("t3_wr_en",      {31'b0, btb_wr_en}, 32'd1);
      check("t3_wr_index",   {24'b0, btb_wr_index}, 32'h34);
      check("t3_wr_tag",     {24'b0, btb_wr_tag}, 32'h12);
      check("t3_wr_target",  {16'b0, btb_wr_target}, 32'h1240);
      tick();
      check("t3_flush_pulse", {31'b0, flush}, 32'd0);
      check("t3_drained",     {31'b0, btb_wr_en}, 32'd0);

      // 4: correct predictions; counter saturation at 00.
      present(16'h2000, 16'h2010, 1'b1, 16'h2010);
      tick();
      res_valid = 1'b0;
      check("t4_no_flush_taken", {31'b0, flush}, 32'd0);
      check("t4_pred_taken",     {30'b0, pred_state}, 32'd3);
      for (int k = 0; k < 4; k++) begin
         present(16'h2100 + 16'(k * 4), 16'h2200, 1'b0, 16'h2101 + 16'(k * 4));
         tick();
         check("t4_pred_nt",     {30'b0, pred_state}, exp_pred[k]);
         check("t4_no_flush_nt", {31'b0, flush}, 32'd0);
      end
      res_valid = 1'b0;
      repeat (3) tick();

      // 5: write port stalled; queue fills at four entries, then drains.
      btb_wr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         present(16'h3010 + 16'(k), 16'h3100 + 16'(k), 1'b1, 16'h3100 + 16'(k));
         check("t5_ready_fill", {31'b0, res_ready}, (k < 4) ? 32'd1 : 32'd0);
         tick();
      end
      res_valid = 1'b0;
      check("t5_full_ready", {31'b0, res_ready}, 32'd0);
      btb_wr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t5_drain_en",    {31'b0, btb_wr_en}, 32'd1);
         check("t5_drain_index", {24'b0, btb_wr_index}, 32'h10 + k);
         check("t5_drain_tgt",   {16'b0, btb_wr_target}, 32'h3100 + k);
         tick();
         check("t5_ready_after_pop", {31'b0, res_ready}, 32'd1);
      end
      check("t5_empty", {31'b0, btb_wr_en}, 32'd0);

      // 6: PC wrap and back-to-back mispredicts (not-taken, then taken).
      present(16'hFFFF, 16'h0100, 1'b0, 16'h1234);
      tick();
      present(16'h4000, 16'h4080, 1'b1, 16'h4001);
      check("t6_flush_wrap",    {31'b0, flush}, 32'd1);
      check("t6_redirect_wrap", {16'b0, redirect_pc}, 32'h0000);
      tick();
      res_valid = 1'b0;
      check("t6_flush_b2b",    {31'b0, flush}, 32'd1);
      check("t6_redirect_tkn", {16'b0, redirect_pc}, 32'h4080);
      tick();
      check("t6_flush_end", {31'b0, flush}, 32'd0);

`ifdef BP_STATS_EN
      present(16'h0000, 16'h0000, 1'b0, 16'h5555);
      repeat (65540) tick();
      res_valid = 1'b0;
      tick();
      check("t6_stat_mispred_sat",  {16'b0, stat_mispred}, 32'hFFFF);
      check("t6_stat_branches_sat", {16'b0, stat_branches}, 32'hFFFF);
`endif

      repeat (4) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
